// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered blank/sync, a frame-start pulse
// and sync copies delayed to line up with a PIPE_DLY-stage pixel pipeline.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int PIPE_DLY  = 2
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic       en,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       hs_d,
   output logic       vs_d,
   output logic       frame_start
);
   localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FP + V_SYNC);

   logic [9:0] hc_q, hc_d, vc_q, vc_d;
   logic       blank_q, blank_d, hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;
   logic       h_wrap, v_wrap;

   // Decode from the next counter values so the flags land in the same cycle as DrawX/DrawY.
   always_comb begin
      h_wrap  = hc_q == H_LAST;
      v_wrap  = vc_q == V_LAST;
      hc_d    = en ? (h_wrap ? 10'd0 : hc_q + 10'd1) : hc_q;
      vc_d    = (en && h_wrap) ? (v_wrap ? 10'd0 : vc_q + 10'd1) : vc_q;
      blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
      hsync_d = !((hc_d >= H_SS) && (hc_d < H_SE));
      vsync_d = !((vc_d >= V_SS) && (vc_d < V_SE));
      fs_d    = en && h_wrap && v_wrap;
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         hc_q    <= 10'd0;
         vc_q    <= 10'd0;
         blank_q <= 1'b1;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         blank_q <= blank_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         fs_q    <= fs_d;
      end
   end

   assign DrawX       = hc_q;
   assign DrawY       = vc_q;
   assign blank       = blank_q;
   assign hs          = hsync_q;
   assign vs          = vsync_q;
   assign frame_start = fs_q & en;

   if (PIPE_DLY == 0) begin : g_nodly
      assign hs_d = hsync_q;
      assign vs_d = vsync_q;
   end else begin : g_dly
      logic [PIPE_DLY-1:0] hsr_q, hsr_d, vsr_q, vsr_d;
      always_comb begin
         hsr_d = en ? PIPE_DLY'({hsr_q, hsync_q}) : hsr_q;
         vsr_d = en ? PIPE_DLY'({vsr_q, vsync_q}) : vsr_q;
      end
      always_ff @(posedge vga_clk or posedge reset) begin
         if (reset) begin
            hsr_q <= '1;
            vsr_q <= '1;
         end else begin
            hsr_q <= hsr_d;
            vsr_q <= vsr_d;
         end
      end
      assign hs_d = hsr_q[PIPE_DLY-1];
      assign vs_d = vsr_q[PIPE_DLY-1];
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks default, small-geometry and zero-delay instances against a raster
// model indexed by the number of enabled cycles since reset.
module tb_vga_timing_gen;
   logic       vga_clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic [9:0] bx, by, sx, sy, zx, zy;
   logic       bb, bhs, bvs, bhsd, bvsd, bfs;
   logic       sb, shs, svs, shsd, svsd, sfs;
   logic       zb, zhs, zvs, zhsd, zvsd, zfs;
   logic [25:0] ab, as, az, w;
   int         compared = 0;
   int         mismatched = 0;
   longint     n = 0;

   typedef struct {int x; int y; bit blank; bit hs; bit vs;} exp_t;

   always #5 vga_clk = ~vga_clk;

   vga_timing_gen u_big (
      .vga_clk(vga_clk), .reset(reset), .en(en), .DrawX(bx), .DrawY(by), .blank(bb),
      .hs(bhs), .vs(bvs), .hs_d(bhsd), .vs_d(bvsd), .frame_start(bfs));

   vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_VISIBLE(6), .V_FP(1),
                    .V_SYNC(2), .V_BP(2), .PIPE_DLY(3)) u_small (
      .vga_clk(vga_clk), .reset(reset), .en(en), .DrawX(sx), .DrawY(sy), .blank(sb),
      .hs(shs), .vs(svs), .hs_d(shsd), .vs_d(svsd), .frame_start(sfs));

   vga_timing_gen #(.PIPE_DLY(0)) u_zero (
      .vga_clk(vga_clk), .reset(reset), .en(en), .DrawX(zx), .DrawY(zy), .blank(zb),
      .hs(zhs), .vs(zvs), .hs_d(zhsd), .vs_d(zvsd), .frame_start(zfs));

   assign ab = {bx, by, bb, bhs, bvs, bhsd, bvsd, bfs};
   assign as = {sx, sy, sb, shs, svs, shsd, svsd, sfs};
   assign az = {zx, zy, zb, zhs, zvs, zhsd, zvsd, zfs};

   function automatic exp_t geom(longint k, int hv, int hf, int hsn, int hb, int vv, int vf, int vsn, int vb);
      exp_t e;
      int ht, vt;
      ht = hv + hf + hsn + hb;
      vt = vv + vf + vsn + vb;
      e.x = int'(k % ht);
      e.y = int'((k / ht) % vt);
      e.blank = (e.x < hv) && (e.y < vv);
      e.hs = !((e.x >= hv + hf) && (e.x < hv + hf + hsn));
      e.vs = !((e.y >= vv + vf) && (e.y < vv + vf + vsn));
      return e;
   endfunction

   function automatic logic [25:0] expv(longint k, bit e, int hv, int hf, int hsn, int hb,
                                        int vv, int vf, int vsn, int vb, int d);
      exp_t c, p;
      longint per;
      per = longint'(hv + hf + hsn + hb) * longint'(vv + vf + vsn + vb);
      c = geom(k, hv, hf, hsn, hb, vv, vf, vsn, vb);
      if (k >= d) p = geom(k - d, hv, hf, hsn, hb, vv, vf, vsn, vb);
      else begin
         p = c;
         p.hs = 1'b1;
         p.vs = 1'b1;
      end
      return {10'(c.x), 10'(c.y), c.blank, c.hs, c.vs, p.hs, p.vs, e && k > 0 && k % per == 0};
   endfunction

   function automatic logic [25:0] eb(longint k);
      return expv(k, en, 640, 16, 96, 48, 480, 10, 2, 33, 2);
   endfunction
   function automatic logic [25:0] ez(longint k);
      return expv(k, en, 640, 16, 96, 48, 480, 10, 2, 33, 0);
   endfunction
   function automatic logic [25:0] es(longint k);
      return expv(k, en, 8, 2, 3, 2, 6, 1, 2, 2, 3);
   endfunction

   task automatic tick();
      @(posedge vga_clk);
      if (reset) n = 0;
      else if (en) n++;
      #1;
   endtask

   task automatic hard_reset();
      en = 1'b0;
      reset = 1'b1;
      n = 0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en = 1'b1;
      n = 0;
      #2;
      w = eb(n); compared++;
      if (ab !== w) begin mismatched++; $display("FAIL reset_async_big got %h want %h", ab, w); end
      w = es(n); compared++;
      if (as !== w) begin mismatched++; $display("FAIL reset_async_small got %h want %h", as, w); end
      tick();
      w = eb(n); compared++;
      if (ab !== w) begin mismatched++; $display("FAIL reset_over_en got %h want %h", ab, w); end
      reset = 1'b0;
   endtask

   task automatic test_line();
      int nb, nh;
      hard_reset();
      en = 1'b1;
      nb = 0;
      nh = 0;
      for (int i = 0; i < 800; i++) begin
         tick();
         w = eb(n); compared++;
         if (ab !== w) begin mismatched++; $display("FAIL line_big n=%0d got %h want %h", n, ab, w); end
         w = ez(n); compared++;
         if (az !== w) begin mismatched++; $display("FAIL line_zero n=%0d got %h want %h", n, az, w); end
         if (bb) nb++;
         if (!bhs) nh++;
      end
      compared++;
      if ({bx, by} !== {10'd0, 10'd1}) begin mismatched++; $display("FAIL line_wrap got %0d,%0d want 0,1", bx, by); end
      compared++;
      if (nb != 640) begin mismatched++; $display("FAIL line_blank_count got %0d want 640", nb); end
      compared++;
      if (nh != 96) begin mismatched++; $display("FAIL line_hs_count got %0d want 96", nh); end
   endtask

   task automatic test_pipe();
      bit found;
      hard_reset();
      en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         tick();
         if (bx == 10'd656) found = 1'b1;
      end
      compared++;
      if (!found) begin mismatched++; $display("FAIL pipe_reach got DrawX %0d want 656", bx); end
      compared++;
      if ({bhs, bhsd, zhsd} !== 3'b010) begin mismatched++; $display("FAIL pipe_656 got %b want 010", {bhs, bhsd, zhsd}); end
      tick();
      compared++;
      if ({bx, bhsd} !== {10'd657, 1'b1}) begin mismatched++; $display("FAIL pipe_657 got %0d/%b want 657/1", bx, bhsd); end
      tick();
      compared++;
      if ({bx, bhs, bhsd} !== {10'd658, 1'b0, 1'b0}) begin mismatched++; $display("FAIL pipe_658 got %0d/%b%b want 658/00", bx, bhs, bhsd); end
   endtask

   task automatic test_frame();
      int fs, vl, bad;
      hard_reset();
      en = 1'b1;
      fs = 0;
      vl = 0;
      bad = 0;
      for (int i = 0; i < 330; i++) begin
         tick();
         w = es(n); compared++;
         if (as !== w) begin mismatched++; $display("FAIL frame_small n=%0d got %h want %h", n, as, w); end
         if (sfs) fs++;
         if (!svs) vl++;
         if (sb && sy >= 10'd6) bad++;
      end
      compared++;
      if (fs != 2) begin mismatched++; $display("FAIL frame_pulses got %0d want 2", fs); end
      compared++;
      if (vl != 60) begin mismatched++; $display("FAIL frame_vs_low got %0d want 60", vl); end
      compared++;
      if (bad != 0) begin mismatched++; $display("FAIL frame_vblank got %0d want 0", bad); end
   endtask

   task automatic test_enable_hold();
      hard_reset();
      en = 1'b1;
      repeat (2300) tick();
      compared++;
      if ({bx, by, bhs} !== {10'd700, 10'd2, 1'b0}) begin mismatched++; $display("FAIL hold_reach got %0d,%0d hs=%b want 700,2 hs=0", bx, by, bhs); end
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         w = eb(n); compared++;
         if (ab !== w || bfs !== 1'b0) begin mismatched++; $display("FAIL hold_frozen got %h want %h", ab, w); end
      end
      en = 1'b1;
      tick();
      compared++;
      if ({bx, by} !== {10'd701, 10'd2}) begin mismatched++; $display("FAIL hold_resume got %0d,%0d want 701,2", bx, by); end
   endtask

   task automatic test_reset_mid();
      hard_reset();
      en = 1'b1;
      repeat (116) tick();
      compared++;
      if ({sx, sy, shs, svs} !== {10'd11, 10'd7, 2'b00}) begin mismatched++; $display("FAIL mid_reach got %0d,%0d %b%b want 11,7 00", sx, sy, shs, svs); end
      #3;
      reset = 1'b1;
      n = 0;
      #1;
      w = es(n); compared++;
      if (as !== w) begin mismatched++; $display("FAIL mid_async_small got %h want %h", as, w); end
      w = eb(n); compared++;
      if (ab !== w) begin mismatched++; $display("FAIL mid_async_big got %h want %h", ab, w); end
      w = ez(n); compared++;
      if (az !== w) begin mismatched++; $display("FAIL mid_async_zero got %h want %h", az, w); end
      tick();
      w = es(n); compared++;
      if (as !== w) begin mismatched++; $display("FAIL mid_held got %h want %h", as, w); end
      reset = 1'b0;
      tick();
      compared++;
      if ({bx, by, bfs, sx, sy, sfs} !== {10'd1, 10'd0, 1'b0, 10'd1, 10'd0, 1'b0}) begin
         mismatched++;
         $display("FAIL mid_release got %0d,%0d fs=%b / %0d,%0d fs=%b want 1,0 fs=0", bx, by, bfs, sx, sy, sfs);
      end
   endtask

   task automatic test_random();
      hard_reset();
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 3) != 0);
         tick();
         w = eb(n); compared++;
         if (ab !== w) begin mismatched++; $display("FAIL rand_big n=%0d got %h want %h", n, ab, w); end
         w = es(n); compared++;
         if (as !== w) begin mismatched++; $display("FAIL rand_small n=%0d got %h want %h", n, as, w); end
         w = ez(n); compared++;
         if (az !== w) begin mismatched++; $display("FAIL rand_zero n=%0d got %h want %h", n, az, w); end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_pipe();
      test_frame();
      test_enable_hold();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48, defining horizontal front porch, sync and back porch widths in pixels; H_TOTAL = sum = 800.
REQ-003 SHALL have parameters V_VISIBLE 480, V_FP 10, V_SYNC 2, V_BP 33, in lines; V_TOTAL = sum = 525.
REQ-004 SHALL have parameter PIPE_DLY, default 2, range 0..4, the sync delay in cycles that matches the consumer pixel pipeline (ROM read + colour register).
REQ-005 SHALL have ports, in order:
  vga_clk  input  1  pixel clock; all state on rising edge
  reset  input  1  asynchronous, active-high
  en  input  1  advance enable; low holds all counters and outputs
  DrawX  output  10  current horizontal position
  DrawY  output  10  current vertical position
  blank  output  1  1 = visible region (colour may be driven), 0 = blanked
  hs  output  1  horizontal sync, active-low, aligned with DrawX
  vs  output  1  vertical sync, active-low, aligned with DrawY
  hs_d  output  1  hs delayed PIPE_DLY cycles
  vs_d  output  1  vs delayed PIPE_DLY cycles
  frame_start  output  1  one-cycle pulse at start of each new frame

Function
REQ-006 SHALL hold horizontal counter hc (10 bits) and vertical counter vc (10 bits) as registers; DrawX = hc, DrawY = vc.
REQ-007 When en = 1, hc SHALL increment by 1 per cycle, wrapping H_TOTAL-1 -> 0.
REQ-008 vc SHALL increment only in the cycle hc wraps; V_TOTAL-1 -> 0 when both wrap together.
REQ-009 When en = 0, hc, vc, hs, vs, blank, frame_start and the delay lines SHALL hold; frame_start SHALL be 0 while en = 0.
REQ-010 blank, hs, vs SHALL be registered, computed from next-state counter values, so in every cycle they describe the current (DrawX, DrawY) with no combinational glitch.
REQ-011 blank SHALL be 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-012 hs SHALL be 0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751 default).
REQ-013 vs SHALL be 0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491 default), for all DrawX in those lines.
REQ-014 frame_start SHALL be 1 for exactly the single cycle in which (DrawX, DrawY) = (0,0) reached by wrap from (H_TOTAL-1, V_TOTAL-1); not asserted for the (0,0) cycle following reset.
REQ-015 hs_d/vs_d SHALL be shift registers of depth PIPE_DLY clocked when en = 1; PIPE_DLY = 0 SHALL make hs_d = hs, vs_d = vs combinationally.
REQ-016 Counters SHALL never reach H_TOTAL or V_TOTAL; no out-of-range value is ever output.
REQ-017 Frame period SHALL be exactly H_TOTAL x V_TOTAL enabled cycles (420000 default).

Reset
REQ-018 Assertion of reset SHALL immediately, without clock, force hc = 0, vc = 0, hs = 1, vs = 1, blank = 1, frame_start = 0, all hs_d/vs_d stages = 1.
REQ-019 Reset asserted mid-line or mid-sync SHALL abort the frame; the first enabled edge after deassertion SHALL advance to (1,0).
REQ-020 Reset SHALL override en.

Verification
REQ-021 Reset then en = 1 for 800 cycles -> DrawX runs 0..799, back to 0 with DrawY 0 -> 1; blank = 1 for DrawX 0..639, hs = 0 for DrawX 656..751 only.
REQ-022 Run 420000 enabled cycles -> frame_start pulses once at wrap to (0,0), DrawY 490..491 has vs = 0 for 1600 cycles total, blank = 0 for all DrawY >= 480.
REQ-023 PIPE_DLY = 2: hs falls at DrawX = 656 -> hs_d falls exactly 2 cycles later at DrawX = 658; PIPE_DLY = 0 -> hs_d identical to hs.
REQ-024 Drop en for 5 cycles at (700,100) -> all outputs frozen at (700,100), hs = 0; resume continues at (701,100).
REQ-025 Assert reset at (700,491) during hs/vs low -> same-cycle hs = 1, vs = 1, blank = 1, DrawX = DrawY = 0, no frame_start pulse on release.
